// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32I encode/decode constants for the instruction loader and the decoder.
// Holds the op_sel codes, opcode/funct constants, loader FSM states and field packers.
package instr_encoder_loader_pkg;

   localparam logic [2:0] SEL_ADD  = 3'd0;
   localparam logic [2:0] SEL_OR   = 3'd1;
   localparam logic [2:0] SEL_SLL  = 3'd2;
   localparam logic [2:0] SEL_ADDI = 3'd3;
   localparam logic [2:0] SEL_LH   = 3'd4;
   localparam logic [2:0] SEL_SH   = 3'd5;
   localparam logic [2:0] SEL_BNE  = 3'd6;
   localparam logic [2:0] SEL_ILL  = 3'd7;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_LH   = 3'b001;
   localparam logic [2:0] F3_SH   = 3'b001;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   // Branches reuse this S-type packing; the codebase decoder extracts them the same way.
   function automatic logic [31:0] pack_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
   endfunction

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational field packer: op_sel plus register/immediate fields to an RV32I word.
// Also used by the decoder self-check, so it carries no state.
module instr_packer
   import instr_encoder_loader_pkg::*;
(
   input  logic [2:0]  op_sel,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [11:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (op_sel)
         SEL_ADD:  word = pack_r(F7_BASE, rs2, rs1, F3_ADD, rd, OP_R);
         SEL_OR:   word = pack_r(F7_BASE, rs2, rs1, F3_OR,  rd, OP_R);
         SEL_SLL:  word = pack_r(F7_BASE, rs2, rs1, F3_SLL, rd, OP_R);
         SEL_ADDI: word = pack_i(imm, rs1, F3_ADDI, rd, OP_IMM);
         SEL_LH:   word = pack_i(imm, rs1, F3_LH,   rd, OP_LOAD);
         SEL_SH:   word = pack_s(imm, rs2, rs1, F3_SH,  OP_STORE);
         SEL_BNE:  word = pack_s(imm, rs2, rs1, F3_BNE, OP_BRANCH);
         SEL_ILL:  illegal = 1'b1;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Sequential program loader: encodes one field bundle at a time and strobes it
// into the instruction memory write port at consecutive word addresses.
//
// state | meaning
// IDLE  | ready for a bundle
// WRITE | mem_we high for this single cycle, count advances at the next edge
// FULL  | DEPTH words written, bundles ignored until clear
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int DEPTH     = 3,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = 32,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op_sel,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [11:0]       imm,
   input  logic              clear,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              err_illegal
);

   state_e            state, state_nxt;
   logic [CW-1:0]     count_nxt;
   logic              we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [31:0]       wdata_nxt;
   logic              err_nxt;
   logic [31:0]       word;
   logic              illegal;
   logic              accept;

   instr_packer u_packer (
      .op_sel  (op_sel),
      .rd      (rd),
      .rs1     (rs1),
      .rs2     (rs2),
      .imm     (imm),
      .word    (word),
      .illegal (illegal)
   );

   assign in_ready = (state == ST_IDLE) && !clear;
   assign accept   = in_valid && in_ready;
   assign full     = (state == ST_FULL);

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      we_nxt    = 1'b0;
      addr_nxt  = mem_addr;
      wdata_nxt = mem_wdata;
      err_nxt   = 1'b0;
      // clear wins over everything; an in-flight strobe still finishes since mem_we is registered
      if (clear) begin
         state_nxt = ST_IDLE;
         count_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     err_nxt = 1'b1;
                  end else begin
                     we_nxt    = 1'b1;
                     addr_nxt  = ADDR_W'(BASE_ADDR) + ADDR_W'(count);
                     wdata_nxt = word;
                     state_nxt = ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               count_nxt = count + CW'(1);
               state_nxt = (count + CW'(1) == CW'(DEPTH)) ? ST_FULL : ST_IDLE;
            end
            ST_FULL: begin
               state_nxt = ST_FULL;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         count       <= '0;
         mem_we      <= 1'b0;
         mem_addr    <= ADDR_W'(BASE_ADDR);
         mem_wdata   <= '0;
         err_illegal <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         mem_we      <= we_nxt;
         mem_addr    <= addr_nxt;
         mem_wdata   <= wdata_nxt;
         err_illegal <= err_nxt;
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: table of encodings plus hand-written
// sequences for FULL, illegal op, clear priority and asynchronous reset.
module tb_instr_encoder_loader;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op_sel;
   logic [4:0]  rd, rs1, rs2;
   logic [11:0] imm;
   logic        clear;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  count;
   logic        full;
   logic        err_illegal;

   int checks = 0;
   int errors = 0;

   instr_encoder_loader #(.DEPTH(3), .BASE_ADDR(0), .ADDR_W(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op_sel      (op_sel),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .imm         (imm),
      .clear       (clear),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .count       (count),
      .full        (full),
      .err_illegal (err_illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] imm;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      #1;
      chk("clear_count", 32'(count), 32'd0);
      chk("clear_full", 32'(full), 32'd0);
      chk("clear_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
   endtask

   // Called at a negedge; returns at a negedge after the strobe has retired.
   task automatic send(input logic [2:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs1,
                       input logic [4:0] f_rs2, input logic [11:0] f_imm,
                       input logic [31:0] exp_w, input logic [31:0] exp_a,
                       input logic [1:0] exp_cnt, input string tag);
      op_sel = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2; imm = f_imm;
      in_valid = 1'b1;
      #1;
      chk({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      chk({tag, "_we"}, 32'(mem_we), 32'd1);
      chk({tag, "_addr"}, mem_addr, exp_a);
      chk({tag, "_wdata"}, mem_wdata, exp_w);
      chk({tag, "_ready_write"}, 32'(in_ready), 32'd0);
      @(negedge clock);
      #1;
      chk({tag, "_we_off"}, 32'(mem_we), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
      chk({tag, "_full"}, 32'(full), (exp_cnt == 2'd3) ? 32'd1 : 32'd0);
      @(negedge clock);
   endtask

   initial begin
      //          op    rd     rs1    rs2    imm       expected word
      vecs[0] = '{3'd0, 5'd3,  5'd1,  5'd2,  12'h000, 32'h002081B3}; // ADD
      vecs[1] = '{3'd3, 5'd5,  5'd0,  5'd0,  12'hFFF, 32'hFFF00293}; // ADDI
      vecs[2] = '{3'd1, 5'd6,  5'd1,  5'd2,  12'h000, 32'h0020E333}; // OR
      vecs[3] = '{3'd4, 5'd4,  5'd1,  5'd0,  12'h008, 32'h00809203}; // LH
      vecs[4] = '{3'd5, 5'd0,  5'd1,  5'd2,  12'h004, 32'h00209223}; // SH
      vecs[5] = '{3'd6, 5'd0,  5'd1,  5'd2,  12'h010, 32'h00209863}; // BNE
      vecs[6] = '{3'd2, 5'd7,  5'd8,  5'd9,  12'h000, 32'h009413B3}; // SLL
      vecs[7] = '{3'd5, 5'd0,  5'd3,  5'd4,  12'hFE5, 32'hFE4192A3}; // SH, high imm
      vecs[8] = '{3'd0, 5'd0,  5'd31, 5'd31, 12'h000, 32'h01FF8033}; // ADD x0

      reset = 1'b1; in_valid = 1'b0; clear = 1'b0;
      op_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_err", 32'(err_illegal), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      #1;
      chk("rst_ready", 32'(in_ready), 32'd1);
      @(negedge clock);

      for (int i = 0; i < 9; i++) begin
         if (i % 3 == 0) do_clear();
         send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
              vecs[i].exp_word, 32'(i % 3), 2'((i % 3) + 1), $sformatf("vec%0d", i));
      end

      // FULL: bundle ignored, no error
      #1;
      chk("full_ready", 32'(in_ready), 32'd0);
      op_sel = 3'd0; in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      chk("full_we", 32'(mem_we), 32'd0);
      chk("full_err", 32'(err_illegal), 32'd0);
      chk("full_count", 32'(count), 32'd3);
      @(negedge clock);
      do_clear();
      send(3'd0, 5'd3, 5'd1, 5'd2, 12'h000, 32'h002081B3, 32'd0, 2'd1, "after_clear");

      // illegal op_sel
      op_sel = 3'd7; in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      chk("ill_err", 32'(err_illegal), 32'd1);
      chk("ill_we", 32'(mem_we), 32'd0);
      chk("ill_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
      #1;
      chk("ill_err_off", 32'(err_illegal), 32'd0);
      chk("ill_count", 32'(count), 32'd1);

      // clear and in_valid together: nothing consumed
      @(negedge clock);
      op_sel = 3'd3; in_valid = 1'b1; clear = 1'b1;
      #1;
      chk("clrv_ready", 32'(in_ready), 32'd0);
      @(negedge clock);
      in_valid = 1'b0; clear = 1'b0;
      #1;
      chk("clrv_we", 32'(mem_we), 32'd0);
      chk("clrv_count", 32'(count), 32'd0);
      @(negedge clock);
      #1;
      chk("clrv_we2", 32'(mem_we), 32'd0);
      @(negedge clock);

      // async reset in the middle of a WRITE cycle
      send(3'd1, 5'd6, 5'd1, 5'd2, 12'h000, 32'h0020E333, 32'd0, 2'd1, "pre_rst");
      op_sel = 3'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      chk("mid_we", 32'(mem_we), 32'd1);
      chk("mid_addr", mem_addr, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_we", 32'(mem_we), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      chk("arst_wdata", mem_wdata, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      #1;
      chk("arst_count_hold", 32'(count), 32'd0);
      @(negedge clock);
      send(3'd4, 5'd4, 5'd1, 5'd0, 12'h008, 32'h00809203, 32'd0, 2'd1, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Counterpart of the instruction-memory decode path: takes decoded fields (mnemonic select, rd, rs1, rs2, imm) and packs them into 32-bit RV32I words.
- Writes each word sequentially into the instruction memory write port, so testbenches and the boot path can load programs without a file.
- Supported set: ADD, OR, SLL, ADDI, LH, SH, BNE.

Parameters:
- DEPTH, 3, number of instruction words in the target memory; the address counter wraps to FULL at DEPTH.
- BASE_ADDR, 0, word index of the first write.
- ADDR_W, 32, width of mem_addr.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- op_sel  in  3  0=ADD 1=OR 2=SLL 3=ADDI 4=LH 5=SH 6=BNE 7=illegal.
- rd, rs1, rs2  in  5 each  register indices; ignored where the format has none.
- imm  in  12  immediate; ignored for R-type.
- clear  in  1  synchronous restart of the load sequence.
- mem_we  out  1  write strobe to instruction memory.
- mem_addr  out  ADDR_W  word index (BASE_ADDR + count).
- mem_wdata  out  32  encoded instruction.
- count  out  $clog2(DEPTH+1)  words written so far.
- full  out  1  DEPTH words written.
- err_illegal  out  1  one-cycle pulse on illegal op_sel.

Behaviour:
- Reset (async, active-high): state=IDLE, count=0; mem_we, full and err_illegal are 0; mem_addr=BASE_ADDR; mem_wdata=0.
- FSM states are IDLE, WRITE and FULL. in_ready = (state==IDLE) && !clear.
- IDLE, accept (in_valid && in_ready) with legal op: on the next edge, register mem_wdata = encode(fields), mem_addr = BASE_ADDR+count, mem_we=1, and go to WRITE. Latency is 1 cycle from accept to strobe.
- IDLE, accept with op_sel=7: no write. err_illegal=1 for exactly one cycle. Stay in IDLE; count unchanged.
- WRITE: mem_we is high for exactly this one cycle.
  - At the next edge: mem_we=0 and count+1.
  - If count+1==DEPTH, go to FULL (full=1); else go to IDLE.
  - Maximum throughput is 1 word per 2 cycles.
- FULL: in_ready=0; in_valid is ignored, with no error.
- clear (any state):
  - At the next edge: count=0, full=0, state=IDLE.
  - A write already strobing in WRITE still completes that cycle.
  - clear takes priority over a same-cycle accept; the bundle is not consumed because in_ready=0.
- Encoding, opcode / funct3 / funct7:
  - ADD: 0110011 / 000 / 0000000. OR: 0110011 / 110 / 0000000. SLL: 0110011 / 001 / 0000000.
  - R-type layout: {funct7, rs2, rs1, funct3, rd, opcode}.
  - ADDI: 0010011 / 000. LH: 0000011 / 001. I-type layout: {imm[11:0], rs1, funct3, rd, opcode}.
  - SH: 0100011 / 001. S-type layout: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - BNE: 1100011 / 001. It is packed exactly like S-type ({imm[11:5]}→[31:25], {imm[4:0]}→[11:7]), not the standard B scramble, to match the codebase decoder's field extraction.
- Fields are encoded as presented; there is no range check. x0 as rd is legal.
- Encoding is combinational inside the block; outputs are registered.

Decomposition:
- Shared package: op_sel codes, 7-bit opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH), funct3/funct7 constants. The decoder uses the same package.
- Sub-module instr_packer: pure combinational, op_sel + fields → {word, illegal}. It is reusable by the decoder's self-check.

Test Plan:
- ADD rd=3 rs1=1 rs2=2 → one cycle after accept: mem_we=1, mem_addr=0, mem_wdata=0x002081B3; count=1 afterwards.
- ADDI rd=5 rs1=0 imm=0xFFF, then OR rd=6 rs1=1 rs2=2 → writes 0xFFF00293 @0, then 0x0020E333 @1. in_ready is low during each WRITE cycle.
- LH rd=4 rs1=1 imm=8 → 0x00809203. SH rs1=1 rs2=2 imm=4 → 0x00209223. BNE rs1=1 rs2=2 imm=0x010 → 0x00209863.
- Three legal writes with DEPTH=3 → full=1 and in_ready=0. A 4th in_valid gives no mem_we and no err_illegal. clear → count=0, and the next write lands at address 0.
- op_sel=7 → err_illegal high for 1 cycle, no mem_we, count unchanged, in_ready back high the next cycle.
- Assert reset mid-WRITE (asynchronously) → mem_we drops immediately, count=0, state IDLE. clear and in_valid asserted in the same cycle → bundle not accepted, no write.
